// File: rtl/class_hvec_stream.sv
// Writable class-hypervector store that streams one class's frames over valid/ready.
// Optional macro CLASS_HVEC_XOR_UPDATE_EN enables XOR-accumulate writes via wr_xor.
module class_hvec_stream #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int NUM_FRAMES         = 3,
  localparam int CID_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int FIDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CID_W-1:0]              req_class_id,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DI_PARALLEL_W_BITS-1:0] out_data,
  output logic [FIDX_W-1:0]             out_frame_index,
  output logic                          out_last,
  output logic                          cls_err,
  input  logic                          wr_en,
  output logic                          wr_ready,
  input  logic [CID_W-1:0]              wr_class_id,
  input  logic [FIDX_W-1:0]             wr_frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] wr_data,
  input  logic                          wr_xor
);

  localparam int W  = DI_PARALLEL_W_BITS;
  localparam int NE = NUM_CLASSES * NUM_FRAMES;
  localparam int AW = CID_W + FIDX_W;
  localparam logic [CID_W:0]    NC = (CID_W+1)'(NUM_CLASSES);
  localparam logic [FIDX_W:0]   NF = (FIDX_W+1)'(NUM_FRAMES);
  localparam logic [FIDX_W-1:0] LASTF = FIDX_W'(NUM_FRAMES - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nx;

  logic [W-1:0]      mem [NE];
  logic [CID_W-1:0]  id_q;
  logic [FIDX_W-1:0] ptr;

  logic              wr_ok;
  logic              req_acc;
  logic              id_ok;
  logic              adv;
  logic              done;
  logic [FIDX_W-1:0] nxt_f;
  logic [CID_W-1:0]  rd_cid;
  logic [AW-1:0]     wa;
  logic [AW-1:0]     ra;
  logic [W-1:0]      wdata;

  always_comb begin
    wr_ready = (state == IDLE);
    req_ready = (state == IDLE) && !wr_en;
    wr_ok = wr_en && wr_ready &&
            ({1'b0, wr_class_id} < NC) &&
            ({1'b0, wr_frame_index} < NF);
    req_acc = req_valid && req_ready;
    id_ok = ({1'b0, req_class_id} < NC);
    adv = (state == STREAM) && out_valid && out_ready;
    done = adv && (ptr == LASTF);
    nxt_f = (state == IDLE) ? '0 : ptr + 1'b1;
    rd_cid = (state == IDLE) ? req_class_id : id_q;
    wa = AW'(wr_class_id) * AW'(NUM_FRAMES)
       + AW'(wr_frame_index);
    ra = AW'(rd_cid) * AW'(NUM_FRAMES) + AW'(nxt_f);
  end

`ifdef CLASS_HVEC_XOR_UPDATE_EN
  always_comb begin
    wdata = wr_data;
    if (wr_xor) wdata = mem[wa] ^ wr_data;
  end
`else
  logic unused_xor;
  assign unused_xor = wr_xor;
  always_comb wdata = wr_data;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (req_acc && id_ok) state_nx = STREAM;
      STREAM: if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wdata;
    end
  end

  // Next frame is fetched on the accepting edge, so frames run back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q            <= '0;
      ptr             <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_frame_index <= '0;
      out_last        <= 1'b0;
      cls_err         <= 1'b0;
    end else begin
      cls_err <= req_acc && !id_ok;
      if (req_acc && id_ok) begin
        id_q            <= req_class_id;
        ptr             <= '0;
        out_valid       <= 1'b1;
        out_data        <= mem[ra];
        out_frame_index <= '0;
        out_last        <= (LASTF == '0);
      end else if (done) begin
        out_valid <= 1'b0;
      end else if (adv) begin
        ptr             <= nxt_f;
        out_data        <= mem[ra];
        out_frame_index <= nxt_f;
        out_last        <= (nxt_f == LASTF);
      end
    end
  end

endmodule

// File: tb/tb_class_hvec_stream.sv
// Scoreboard bench for class_hvec_stream (NUM_CLASSES=6, NUM_FRAMES=3, W=64).
// Expected frames come from a bench-side storage model; honours CLASS_HVEC_XOR_UPDATE_EN.
module tb_class_hvec_stream;

  localparam int W  = 64;
  localparam int NC = 6;
  localparam int NF = 3;
  localparam int CW = 3;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_class_id;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [FW-1:0] out_frame_index;
  logic          out_last;
  logic          cls_err;
  logic          wr_en;
  logic          wr_ready;
  logic [CW-1:0] wr_class_id;
  logic [FW-1:0] wr_frame_index;
  logic [W-1:0]  wr_data;
  logic          wr_xor;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [FW-1:0] f;
    logic          l;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] model [NC*NF];
  int           errors = 0;
  int           checks = 0;

  class_hvec_stream #(
    .DI_PARALLEL_W_BITS(W),
    .NUM_CLASSES(NC),
    .NUM_FRAMES(NF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_class_id(req_class_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_frame_index(out_frame_index),
    .out_last(out_last),
    .cls_err(cls_err),
    .wr_en(wr_en),
    .wr_ready(wr_ready),
    .wr_class_id(wr_class_id),
    .wr_frame_index(wr_frame_index),
    .wr_data(wr_data),
    .wr_xor(wr_xor)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < NC*NF; i++) model[i] = '0;
  endtask

  task automatic push_class(input int c);
    exp_t e;
    for (int f = 0; f < NF; f++) begin
      e.d = model[c*NF+f];
      e.f = FW'(f);
      e.l = (f == NF-1);
      sbq.push_back(e);
    end
  endtask

  task automatic do_write(input int c, input int f,
                          input logic [W-1:0] d, input logic x);
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready idle: got %b want 1", wr_ready);
    end
    wr_en = 1'b1;
    wr_class_id = CW'(c);
    wr_frame_index = FW'(f);
    wr_data = d;
    wr_xor = x;
    @(negedge clk);
    wr_en = 1'b0;
    wr_xor = 1'b0;
    if (c < NC && f < NF) begin
`ifdef CLASS_HVEC_XOR_UPDATE_EN
      if (x) model[c*NF+f] = model[c*NF+f] ^ d;
      else   model[c*NF+f] = d;
`else
      model[c*NF+f] = d;
`endif
    end
  endtask

  task automatic issue_req(input int c);
    @(negedge clk);
    req_valid = 1'b1;
    req_class_id = CW'(c);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready idle: got %b want 1", req_ready);
    end
    if (c < NC) push_class(c);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Runs at a negedge where frame 0 should already be valid.
  task automatic consume(input int stall_f, input int stall_n);
    exp_t e;
    int   budget;
    int   stalled;
    budget = 0;
    stalled = 0;
    while (sbq.size() > 0) begin
      budget++;
      checks++;
      if (budget > 40) begin
        errors++;
        $display("FAIL stream timeout: %0d frames left", sbq.size());
        sbq.delete();
        break;
      end
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid in stream: got %b want 1", out_valid);
        sbq.delete();
        break;
      end
      e = sbq[0];
      checks++;
      if ({out_data, out_frame_index, out_last} !== e) begin
        errors++;
        $display("FAIL frame: got d=%h f=%0d l=%b want d=%h f=%0d l=%b",
                 out_data, out_frame_index, out_last, e.d, e.f, e.l);
      end
      checks++;
      if (wr_ready !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy ready: got wr=%b req=%b want 0 0",
                 wr_ready, req_ready);
      end
      if (int'(e.f) == stall_f && stalled < stall_n) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
        void'(sbq.pop_front());
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_valid after last: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_class_id = '0;
    out_ready = 1'b0;
    wr_en = 1'b0;
    wr_class_id = '0;
    wr_frame_index = '0;
    wr_data = '0;
    wr_xor = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_frame_index, out_last, cls_err} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got v=%b d=%h f=%0d l=%b e=%b want 0",
               out_valid, out_data, out_frame_index, out_last, cls_err);
    end
    checks++;
    if (wr_ready !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset ready: got wr=%b req=%b want 1 1",
               wr_ready, req_ready);
    end
  endtask

  task automatic test_zero_stream();
    issue_req(0);
    consume(-1, 0);
  endtask

  task automatic test_ordered_stream();
    do_write(2, 0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    do_write(2, 1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
    do_write(2, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue_req(2);
    consume(-1, 0);
  endtask

  task automatic test_backpressure();
    issue_req(2);
    consume(1, 5);
  endtask

  task automatic test_write_priority();
    @(negedge clk);
    wr_en = 1'b1;
    wr_class_id = 3'd1;
    wr_frame_index = 2'd0;
    wr_data = 64'h1234_5678_9ABC_DEF0;
    req_valid = 1'b1;
    req_class_id = 3'd1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL req_ready during write: got %b want 0", req_ready);
    end
    @(negedge clk);
    wr_en = 1'b0;
    model[1*NF+0] = 64'h1234_5678_9ABC_DEF0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready after write: got %b want 1", req_ready);
    end
    push_class(1);
    @(negedge clk);
    req_valid = 1'b0;
    consume(-1, 0);
  endtask

  task automatic test_invalid_id();
    issue_req(7);
    checks++;
    if (cls_err !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad id pulse: got err=%b v=%b want 1 0",
               cls_err, out_valid);
    end
    @(negedge clk);
    checks++;
    if (cls_err !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad id after: got err=%b v=%b want 0 0",
               cls_err, out_valid);
    end
    do_write(7, 0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    do_write(0, 3, 64'hCAFE_CAFE_CAFE_CAFE, 1'b0);
    for (int c = 0; c < 3; c++) begin
      issue_req(c);
      consume(-1, 0);
    end
  endtask

  task automatic test_xor_update();
    do_write(3, 1, 64'h5A5A_0000_FFFF_1234, 1'b0);
    do_write(3, 1, 64'h5A5A_0000_FFFF_1234, 1'b1);
    do_write(3, 2, 64'h00FF_00FF_00FF_00FF, 1'b1);
    issue_req(3);
    consume(-1, 0);
  endtask

  task automatic test_reset_midstream();
    issue_req(2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_frame_index, out_last} !== '0) begin
      errors++;
      $display("FAIL async reset: got v=%b d=%h f=%0d l=%b want 0",
               out_valid, out_data, out_frame_index, out_last);
    end
    sbq.delete();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    issue_req(2);
    consume(-1, 0);
  endtask

  task automatic test_back_to_back();
    do_write(5, 0, 64'h1111_2222_3333_4444, 1'b0);
    do_write(5, 2, 64'h8000_0000_0000_0001, 1'b0);
    issue_req(5);
    consume(-1, 0);
    issue_req(5);
    consume(2, 2);
  endtask

  initial begin
    test_reset();
    test_zero_stream();
    test_ordered_stream();
    test_backpressure();
    test_write_priority();
    test_invalid_id();
    test_xor_update();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
